// File: rtl/counter_arbiter_if.sv
// rtl/counter_arbiter_if.sv - requester and counter handshake bundle for counter_arbiter
interface counter_arbiter_if #(
  parameter int STEPS_W = 4
);
  logic               req0;
  logic               req1;
  logic [1:0]         mode0;
  logic [1:0]         mode1;
  logic [3:0]         d0;
  logic [3:0]         d1;
  logic [STEPS_W-1:0] steps0;
  logic [STEPS_W-1:0] steps1;
  logic               ctr_rco;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic               ctr_enable;
  logic [1:0]         ctr_mode;
  logic [3:0]         ctr_d;
  logic               busy;
  logic [3:0]         rco_hits;
  logic               aborted;

  modport master (
    output req0, req1, mode0, mode1, d0, d1, steps0, steps1, ctr_rco,
    input  gnt0, gnt1, done0, done1, ctr_enable, ctr_mode, ctr_d, busy, rco_hits, aborted
  );

  modport slave (
    input  req0, req1, mode0, mode1, d0, d1, steps0, steps1, ctr_rco,
    output gnt0, gnt1, done0, done1, ctr_enable, ctr_mode, ctr_d, busy, rco_hits, aborted
  );
endinterface

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin arbiter running counter commands from two requesters
// Define COUNTER_ARB_RCO_ABORT_EN to end RUN early on ctr_rco and flag it on aborted.
module counter_arbiter #(
  parameter int STEPS_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  counter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;   // 1: requester 1 served last, so requester 0 wins a tie
  logic               cur_q, cur_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         dval_q, dval_d;
  logic               busy_q, busy_d;
  logic [3:0]         hits_q, hits_d;
  logic               abort_q, abort_d;

  logic               win;
  logic [1:0]         win_mode;
  logic [3:0]         win_dval;
  logic [STEPS_W-1:0] win_steps;
  logic               last_run;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    en_d      = 1'b0;
    mode_d    = mode_q;
    dval_d    = dval_q;
    hits_d    = hits_q;
    abort_d   = abort_q;
    win       = 1'b0;
    win_mode  = 2'b00;
    win_dval  = 4'd0;
    win_steps = '0;
    last_run  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          win_mode  = win ? bus.mode1  : bus.mode0;
          win_dval  = win ? bus.d1     : bus.d0;
          win_steps = win ? bus.steps1 : bus.steps0;
          cur_d     = win;
          mode_d    = win_mode;
          dval_d    = win_dval;
          // A load is a single cycle, and zero steps still runs once.
          rem_d     = (win_mode == 2'b11 || win_steps == '0) ? STEPS_W'(1) : win_steps;
          gnt0_d    = ~win;
          gnt1_d    = win;
          en_d      = 1'b1;
          hits_d    = 4'd0;
          abort_d   = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (bus.ctr_rco && hits_q != 4'hF) hits_d = hits_q + 4'd1;
        last_run = (rem_q == STEPS_W'(1));
`ifdef COUNTER_ARB_RCO_ABORT_EN
        if (bus.ctr_rco) begin
          last_run = 1'b1;
          abort_d  = 1'b1;
        end
`endif
        rem_d = last_run ? '0 : rem_q - 1'b1;
        if (last_run) begin
          state_d = DONE;
          done0_d = ~cur_q;
          done1_d = cur_q;
        end else begin
          en_d = 1'b1;
        end
      end

      DONE: begin
        last_d  = cur_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      rem_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      en_q    <= 1'b0;
      mode_q  <= 2'b00;
      dval_q  <= 4'd0;
      busy_q  <= 1'b0;
      hits_q  <= 4'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      dval_q  <= dval_d;
      busy_q  <= busy_d;
      hits_q  <= hits_d;
      abort_q <= abort_d;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.ctr_enable = en_q;
  assign bus.ctr_mode   = mode_q;
  assign bus.ctr_d      = dval_q;
  assign bus.busy       = busy_q;
  assign bus.rco_hits   = hits_q;
  assign bus.aborted    = abort_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - randomized bench for counter_arbiter against an operation-timeline model
module tb_counter_arbiter;

  localparam int SW = 5;
`ifdef COUNTER_ARB_RCO_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  counter_arbiter_if #(.STEPS_W(SW)) bus ();

  counter_arbiter #(.STEPS_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one operation is described by its start cycle s and RUN length L.
  int c = 0;
  bit have_op = 0;
  int s = 0;
  int L = 0;
  bit who = 0;
  bit last = 1;
  int hits = 0;
  bit ab = 0;
  int emode = 0;
  int ed = 0;
  bit pend [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, c, got, exp);
    end
  endtask

  task automatic set_cmd(input int i, input bit r, input int mode, input int d, input int steps);
    if (i == 0) begin
      bus.req0 = r; bus.mode0 = mode[1:0]; bus.d0 = d[3:0]; bus.steps0 = steps[SW-1:0];
    end else begin
      bus.req1 = r; bus.mode1 = mode[1:0]; bus.d1 = d[3:0]; bus.steps1 = steps[SW-1:0];
    end
  endtask

  task automatic model_edge();
    int mode, steps;
    c++;
    if (!reset) begin
      have_op = 0; last = 1; hits = 0; ab = 0; emode = 0; ed = 0;
      return;
    end
    if (have_op) begin
      if (c - 1 >= s && c - 1 < s + L && bus.ctr_rco) begin
        if (hits < 15) hits++;
        if (ABORT_EN) begin
          L  = c - s;
          ab = 1;
        end
      end
      if (c - 1 == s + L) begin
        last    = who;
        have_op = 0;
      end
    end else if (bus.req0 || bus.req1) begin
      who   = (bus.req0 && bus.req1) ? !last : bus.req1;
      mode  = who ? int'(bus.mode1)  : int'(bus.mode0);
      steps = who ? int'(bus.steps1) : int'(bus.steps0);
      ed    = who ? int'(bus.d1)     : int'(bus.d0);
      emode = mode;
      L     = (mode == 3 || steps == 0) ? 1 : steps;
      s     = c;
      have_op = 1;
      hits  = 0;
      ab    = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt0",       bus.gnt0,       int'(have_op && c == s && !who));
    check("gnt1",       bus.gnt1,       int'(have_op && c == s && who));
    check("done0",      bus.done0,      int'(have_op && c == s + L && !who));
    check("done1",      bus.done1,      int'(have_op && c == s + L && who));
    check("ctr_enable", bus.ctr_enable, int'(have_op && c < s + L));
    check("busy",       bus.busy,       int'(have_op));
    check("ctr_mode",   bus.ctr_mode,   emode);
    check("ctr_d",      bus.ctr_d,      ed);
    check("rco_hits",   bus.rco_hits,   hits);
    check("aborted",    bus.aborted,    int'(ab));
  endtask

  // Requester i issues one command, drops req once granted; optional rco/reset at a RUN offset.
  task automatic serve(input int i, input int mode, input int d, input int steps,
                       input int rco_at, input int reset_at);
    bit granted;
    int k;
    granted = 0;
    set_cmd(i, 1, mode, d, steps);
    for (int n = 0; n < 80; n++) begin
      step();
      if (!granted && have_op && c == s && int'(who) == i) begin
        granted = 1;
        set_cmd(i, 0, mode, d, steps);
      end
      if (granted) begin
        k = c - s;
        bus.ctr_rco = (k + 1 == rco_at);
        reset = !(k + 1 == reset_at);
        if (!have_op) break;
      end
    end
    bus.ctr_rco = 1'b0;
    reset = 1'b1;
    check("served", int'(granted), 1);
    check("drained", int'(have_op), 0);
  endtask

  task automatic drive_random(input int req_pct, input int rco_pct, input int rst_pct);
    int steps;
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && have_op && c == s && int'(who) == i) begin
        pend[i] = 0;
        set_cmd(i, 0, 0, 0, 0);
      end
      if (!pend[i] && $urandom_range(99) < req_pct) begin
        pend[i] = 1;
        steps = ($urandom_range(7) == 0) ? 0 : $urandom_range((1 << SW) - 1);
        set_cmd(i, 1, $urandom_range(3), $urandom_range(15), steps);
      end
    end
    bus.ctr_rco = ($urandom_range(99) < rco_pct);
    reset = !($urandom_range(99) < rst_pct);
  endtask

  initial begin
    bit exp_who;
    reset = 1'b0;
    bus.ctr_rco = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    pend[0] = 0;
    pend[1] = 0;

    // Reset held with req0 pending, then a 5-step increment.
    set_cmd(0, 1, 2, 0, 5);
    step();
    step();
    reset = 1'b1;
    serve(0, 2, 0, 5, -1, -1);
    step();

    serve(1, 3, 9, 7, -1, -1);
    step();
    serve(0, 2, 4, 0, -1, -1);
    step();
    serve(1, 2, 3, 8, 2, -1);
    step();
    serve(0, 2, 5, 6, -1, 1);
    step();
    step();

    // Both requesters held: grants alternate starting with requester 0.
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_cmd(0, 1, 2, 1, 2);
    set_cmd(1, 1, 1, 2, 3);
    exp_who = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (bus.gnt0 || bus.gnt1) begin
        check("alternate", int'(bus.gnt1), int'(exp_who));
        exp_who = !exp_who;
      end
    end
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    for (int n = 0; n < 10; n++) step();

    for (int n = 0; n < 1500; n++) begin
      drive_random(30, 10, 1);
      step();
    end
    for (int n = 0; n < 1500; n++) begin
      drive_random(60, 85, 0);
      step();
    end
    for (int n = 0; n < 1000; n++) begin
      drive_random(90, 3, 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
